// File: rtl/hazard_tracker_if.sv
// D-stage instruction in, stall and E/M/W destination tags out.
// The pipeline control side is master; hazard_tracker is slave.
interface hazard_tracker_if;
   logic [31:0] ir_d;
   logic        stall;
   logic [4:0]  dst_e, dst_m, dst_w;
   logic [1:0]  tnew_e, tnew_m;
   logic        wen_e, wen_m, wen_w;

   modport master (
      output ir_d,
      input  stall, dst_e, dst_m, dst_w, tnew_e, tnew_m, wen_e, wen_m, wen_w
   );
   modport slave (
      input  ir_d,
      output stall, dst_e, dst_m, dst_w, tnew_e, tnew_m, wen_e, wen_m, wen_w
   );
endinterface

// File: rtl/hazard_tracker.sv
// Decodes D-stage destination/source tags, tracks them down E->M->W and raises stall.
// Define HAZARD_STALL_CNT_EN to add the saturating stall_cnt output.
module hazard_tracker (
   input  logic        clk,
   input  logic        reset,
`ifdef HAZARD_STALL_CNT_EN
   output logic [31:0] stall_cnt,
`endif
   hazard_tracker_if.slave hz
);

   typedef struct packed {
      logic [4:0] dst;
      logic       wen;
      logic [1:0] tnew;
   } tag_t;

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J   = 6'h02, OP_JAL = 6'h03,
                          OP_BEQ   = 6'h04, OP_ORI = 6'h0d, OP_LUI = 6'h0f,
                          OP_LW    = 6'h23, OP_SW  = 6'h2b;
   localparam logic [5:0] FN_JR = 6'h08, FN_ADDU = 6'h21, FN_SUBU = 6'h23;

   logic [5:0] op, func;
   logic [4:0] rs, rt, rd;
   assign op   = hz.ir_d[31:26];
   assign rs   = hz.ir_d[25:21];
   assign rt   = hz.ir_d[20:16];
   assign rd   = hz.ir_d[15:11];
   assign func = hz.ir_d[5:0];

   logic unused_shamt;
   assign unused_shamt = ^hz.ir_d[10:6];

   tag_t       tag_d, tag_e, tag_m;
   logic [4:0] dst_w;
   logic       wen_w;
   logic [4:0] dst_raw, src_a, src_b;
   logic [1:0] tnew_raw, use_a, use_b;
   logic       has_dst;

   // Unused source slots are left at register 0, which can never stall.
   always_comb begin
      dst_raw  = 5'd0;
      tnew_raw = 2'd0;
      has_dst  = 1'b0;
      src_a    = 5'd0;
      use_a    = 2'd0;
      src_b    = 5'd0;
      use_b    = 2'd0;
      case (op)
         OP_RTYPE: begin
            if (func == FN_ADDU || func == FN_SUBU) begin
               dst_raw  = rd;
               tnew_raw = 2'd1;
               has_dst  = 1'b1;
               src_a    = rs;
               use_a    = 2'd1;
               src_b    = rt;
               use_b    = 2'd1;
            end else if (func == FN_JR) begin
               src_a = rs;
            end
         end
         OP_ORI: begin
            dst_raw  = rt;
            tnew_raw = 2'd1;
            has_dst  = 1'b1;
            src_a    = rs;
            use_a    = 2'd1;
         end
         OP_LUI: begin
            dst_raw  = rt;
            tnew_raw = 2'd1;
            has_dst  = 1'b1;
         end
         OP_LW: begin
            dst_raw  = rt;
            tnew_raw = 2'd2;
            has_dst  = 1'b1;
            src_a    = rs;
            use_a    = 2'd1;
         end
         OP_SW: begin
            src_a = rs;
            use_a = 2'd1;
            src_b = rt;
            use_b = 2'd2;
         end
         OP_BEQ: begin
            src_a = rs;
            src_b = rt;
         end
         OP_JAL: begin
            dst_raw = 5'd31;
            has_dst = 1'b1;
         end
         default: ;
      endcase
      tag_d.wen  = has_dst && (dst_raw != 5'd0);
      tag_d.dst  = tag_d.wen ? dst_raw  : 5'd0;
      tag_d.tnew = tag_d.wen ? tnew_raw : 2'd0;
   end

   function automatic logic hit(input logic [4:0] s, input logic [1:0] u,
                                input tag_t e, input tag_t m);
      hit = (s != 5'd0) &&
            ((e.wen && e.dst == s && e.tnew > u) ||
             (m.wen && m.dst == s && m.tnew > u));
   endfunction

   logic stall;
   assign stall = hit(src_a, use_a, tag_e, tag_m) | hit(src_b, use_b, tag_e, tag_m);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag_e <= '0;
         tag_m <= '0;
         dst_w <= 5'd0;
         wen_w <= 1'b0;
      end else begin
         tag_e      <= stall ? '0 : tag_d;
         tag_m.dst  <= tag_e.dst;
         tag_m.wen  <= tag_e.wen;
         tag_m.tnew <= (tag_e.tnew != 2'd0) ? tag_e.tnew - 2'd1 : 2'd0;
         dst_w      <= tag_m.dst;
         wen_w      <= tag_m.wen;
      end
   end

`ifdef HAZARD_STALL_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_cnt <= 32'd0;
      else if (stall && stall_cnt != 32'hffff_ffff)
         stall_cnt <= stall_cnt + 32'd1;
   end
`endif

   assign hz.stall  = stall;
   assign hz.dst_e  = tag_e.dst;
   assign hz.dst_m  = tag_m.dst;
   assign hz.dst_w  = dst_w;
   assign hz.tnew_e = tag_e.tnew;
   assign hz.tnew_m = tag_m.tnew;
   assign hz.wen_e  = tag_e.wen;
   assign hz.wen_m  = tag_m.wen;
   assign hz.wen_w  = wen_w;

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed test-plan sequences plus random instruction streams checked against
// a history-queue model of the in-flight instructions.
module tb_hazard_tracker;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   hazard_tracker_if hz ();
`ifdef HAZARD_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   hazard_tracker dut (
      .clk       (clk),
      .reset     (reset),
`ifdef HAZARD_STALL_CNT_EN
      .stall_cnt (stall_cnt),
`endif
      .hz        (hz)
   );

   int errs = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Model: hist[0] is the instruction now in E, hist[1] in M, hist[2] in W.
   typedef struct {int dst; int tnew;} mtag_t;
   typedef struct {int s0; int u0; int s1; int u1;} msrc_t;
   mtag_t hist[$];
   longint mcnt;

   function automatic mtag_t stage(input int k);
      mtag_t b;
      b.dst = 0; b.tnew = 0;
      if (k < hist.size()) return hist[k];
      return b;
   endfunction

   function automatic mtag_t mdecode(input logic [31:0] ir);
      mtag_t t;
      int op, fn, rt, rd;
      op = int'(ir[31:26]); fn = int'(ir[5:0]);
      rt = int'(ir[20:16]); rd = int'(ir[15:11]);
      t.dst = 0; t.tnew = 0;
      if (op == 0 && (fn == 'h21 || fn == 'h23)) begin t.dst = rd; t.tnew = 1; end
      else if (op == 'h0d || op == 'h0f)          begin t.dst = rt; t.tnew = 1; end
      else if (op == 'h23)                        begin t.dst = rt; t.tnew = 2; end
      else if (op == 'h03)                        begin t.dst = 31; t.tnew = 0; end
      if (t.dst == 0) t.tnew = 0;
      return t;
   endfunction

   function automatic msrc_t msrcs(input logic [31:0] ir);
      msrc_t s;
      int op, fn, rs, rt;
      op = int'(ir[31:26]); fn = int'(ir[5:0]);
      rs = int'(ir[25:21]); rt = int'(ir[20:16]);
      s = '{0, 0, 0, 0};
      if (op == 4)                                 s = '{rs, 0, rt, 0};
      else if (op == 0 && fn == 'h08)              s = '{rs, 0, 0, 0};
      else if (op == 0 && (fn == 'h21 || fn == 'h23)) s = '{rs, 1, rt, 1};
      else if (op == 'h0d || op == 'h23)           s = '{rs, 1, 0, 0};
      else if (op == 'h2b)                         s = '{rs, 1, rt, 2};
      return s;
   endfunction

   // A result produced k stages ahead still needs (Tnew - age) cycles.
   function automatic bit blocked(input int s, input int u);
      mtag_t e, m;
      if (s == 0) return 0;
      e = stage(0); m = stage(1);
      return (e.dst == s && e.tnew > u) || (m.dst == s && m.tnew - 1 > u);
   endfunction

   function automatic bit mstall(input logic [31:0] ir);
      msrc_t s;
      s = msrcs(ir);
      return blocked(s.s0, s.u0) || blocked(s.s1, s.u1);
   endfunction

   task automatic check_outputs(input bit exp_stall);
      mtag_t e, m, w;
      e = stage(0); m = stage(1); w = stage(2);
      chk("stall",  32'(hz.stall),  32'(exp_stall));
      chk("dst_e",  32'(hz.dst_e),  32'(e.dst));
      chk("dst_m",  32'(hz.dst_m),  32'(m.dst));
      chk("dst_w",  32'(hz.dst_w),  32'(w.dst));
      chk("tnew_e", 32'(hz.tnew_e), 32'(e.tnew));
      chk("tnew_m", 32'(hz.tnew_m), 32'(m.tnew > 0 ? m.tnew - 1 : 0));
      chk("wen_e",  32'(hz.wen_e),  32'(e.dst != 0));
      chk("wen_m",  32'(hz.wen_m),  32'(m.dst != 0));
      chk("wen_w",  32'(hz.wen_w),  32'(w.dst != 0));
`ifdef HAZARD_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, 32'(mcnt));
`endif
   endtask

   // Holds ir in D until the model releases it; returns the stall cycles seen.
   task automatic issue(input logic [31:0] ir, output int nst);
      bit done, st;
      mtag_t bub;
      bub.dst = 0; bub.tnew = 0;
      nst = 0;
      done = 0;
      for (int k = 0; k < 4 && !done; k++) begin
         @(negedge clk);
         hz.ir_d = ir;
         #1;
         st = mstall(ir);
         check_outputs(st);
         @(posedge clk);
         hist.push_front(st ? bub : mdecode(ir));
         if (hist.size() > 3) void'(hist.pop_back());
         if (st) begin nst++; mcnt++; end
         else done = 1;
      end
      if (!done) chk("stall_bound", 32'(nst), 32'd2);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      hist.delete();
      mcnt = 0;
      check_outputs(1'b0);
      @(negedge clk);
      #2 reset = 1'b0;
   endtask

   function automatic logic [31:0] rtype(input int rs, rt, rd, fn);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
   endfunction
   function automatic logic [31:0] itype(input int op, rs, rt, imm);
      return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
   endfunction

   function automatic logic [31:0] rand_instr();
      int rs, rt, rd, imm;
      rs = $urandom_range(0, 7); rt = $urandom_range(0, 7);
      rd = $urandom_range(0, 7); imm = $urandom_range(0, 65535);
      case ($urandom_range(0, 10))
         0:  return rtype(rs, rt, rd, 'h21);
         1:  return rtype(rs, rt, rd, 'h23);
         2:  return itype('h0d, rs, rt, imm);
         3:  return itype('h0f, 0, rt, imm);
         4:  return itype('h23, rs, rt, imm);
         5:  return itype('h2b, rs, rt, imm);
         6:  return itype('h04, rs, rt, imm);
         7:  return {6'h02, 26'(imm)};
         8:  return {6'h03, 26'(imm)};
         9:  return rtype(rs, 0, 0, 'h08);
         default: return $urandom();
      endcase
   endfunction

   int n;
   logic [31:0] lw8, beq8;

   initial begin
      reset = 1'b1;
      hz.ir_d = 32'd0;
      mcnt = 0;
      lw8  = itype('h23, 0, 8, 0);
      beq8 = itype('h04, 8, 0, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_outputs(1'b0);
      #2 reset = 1'b0;

      for (int i = 0; i < 3; i++) begin
         issue(32'd0, n);
         chk("nop_stall", 32'(n), 32'd0);
      end
      issue(lw8, n);
      issue(rtype(8, 8, 9, 'h21), n);           chk("lw_alu_len", 32'(n), 32'd1);
      #1 chk("alu_dst_e", 32'(hz.dst_e), 32'd9);
      issue(lw8, n);
      issue(beq8, n);                           chk("lw_beq_len", 32'(n), 32'd2);
      issue(itype('h0d, 0, 3, 5), n);
      issue(rtype(3, 0, 0, 'h08), n);           chk("ori_jr_len", 32'(n), 32'd1);
      issue({6'h03, 26'd0}, n);
      #1 chk("jal_dst_e", 32'(hz.dst_e), 32'd31);
      chk("jal_tnew_e", 32'(hz.tnew_e), 32'd0);
      issue(rtype(31, 0, 0, 'h08), n);          chk("jal_jr_len", 32'(n), 32'd0);
      issue(itype('h23, 0, 5, 0), n);
      issue(itype('h2b, 1, 5, 0), n);           chk("lw_swdata_len", 32'(n), 32'd0);
      issue(rtype(1, 2, 0, 'h21), n);
      #1 chk("addu0_wen_e", 32'(hz.wen_e), 32'd0);
      issue(itype('h04, 0, 0, 0), n);           chk("beq0_len", 32'(n), 32'd0);

`ifdef HAZARD_STALL_CNT_EN
      do_reset();
      issue(lw8, n); issue(beq8, n);
      issue(lw8, n); issue(beq8, n);
      #1 chk("stall_cnt_4", stall_cnt, 32'd4);
`endif
      // Reset while beq is stalled behind lw: stall must drop at once.
      issue(lw8, n);
      @(negedge clk);
      hz.ir_d = beq8;
      #1 chk("pre_reset_stall", 32'(hz.stall), 32'd1);
      reset = 1'b1;
      #1;
      hist.delete();
      mcnt = 0;
      chk("mid_reset_stall", 32'(hz.stall), 32'd0);
      check_outputs(1'b0);
      #2 reset = 1'b0;

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 49) == 0) do_reset();
         issue(rand_instr(), n);
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
